// File: rtl/mc_main_ctrl.sv
// mc_main_ctrl: main control FSM of the multicycle MIPS core.
//
// Sequences every instruction through fetch / decode / execute / memory /
// writeback and drives the datapath mux selects and write enables. Outputs
// are decoded from the current state. The exceptions are ir_write / pc_en in
// FETCH, which follow mem_ready_i, and pc_en in the branch states, which
// follows zero_i.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        asynchronous active-high reset (state -> FETCH, write enables forced 0)
//   op_i6        opcode field instr[31:26], sampled in DECODE and MEMADR only
//   zero_i       ALU zero flag (branch resolution)
//   mem_ready_i  unified memory completed the current access this cycle
//   iord_o       memory address select: 0=PC, 1=ALUOut
//   alu_src_a_o  ALU A select: 0=PC, 1=regA
//   alu_src_b_o2 ALU B select: 00=regB, 01=4, 10=SignImm, 11=SignImm<<2
//   alu_op_o2    00=add, 01=sub, 10=use funct (to the ALU decoder)
//   pc_src_o2    00=ALUResult, 01=ALUOut, 10=jump target
//   ir_write_o   instruction register load
//   mem_write_o  memory write strobe
//   reg_write_o  register file write
//   reg_dst_o    destination register: 0=rt, 1=rd
//   mem_to_reg_o writeback source: 0=ALUOut, 1=memory data
//   pc_en_o      PC load = pc_write | (branch & zero_i)
//   illegal_op_o one-cycle pulse in DECODE on an unsupported opcode
//   state_o4     current state, for debug/trace
//
// Optional feature macro: MC_BNE_EN adds bne (opcode 000101) via state BNEEX (12).
// Without it, 000101 is illegal and encoding 12 is treated as undefined.

module mc_main_ctrl #(
    // Must stay at FETCH (0) in production builds.
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] op_i6,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       iord_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o2,
    output logic [1:0] alu_op_o2,
    output logic [1:0] pc_src_o2,
    output logic       ir_write_o,
    output logic       mem_write_o,
    output logic       reg_write_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       pc_en_o,
    output logic       illegal_op_o,
    output logic [3:0] state_o4
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StRtypeEx = 4'd6,
        StRtypeWb = 4'd7,
        StBeqEx   = 4'd8,
        StAddiEx  = 4'd9,
        StAddiWb  = 4'd10,
        StJEx     = 4'd11,
        StBneEx   = 4'd12
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;
`ifdef MC_BNE_EN
    localparam logic [5:0] OpBne   = 6'b000101;
`endif

    state_e state_q, state_d;

    // Raw (ungated) control terms; the write enables are masked by rst_i below.
    logic pc_write, branch_eq, branch_ne;
    logic ir_write_raw, mem_write_raw, reg_write_raw, illegal_raw;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= state_e'(RESET_STATE);
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = StFetch;
        iord_o        = 1'b0;
        alu_src_a_o   = 1'b0;
        alu_src_b_o2  = 2'b00;
        alu_op_o2     = 2'b00;
        pc_src_o2     = 2'b00;
        reg_dst_o     = 1'b0;
        mem_to_reg_o  = 1'b0;
        pc_write      = 1'b0;
        branch_eq     = 1'b0;
        branch_ne     = 1'b0;
        ir_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        illegal_raw   = 1'b0;

        case (state_q)
            StFetch: begin
                alu_src_b_o2 = 2'b01;
                ir_write_raw = mem_ready_i;
                pc_write     = mem_ready_i;
                state_d      = mem_ready_i ? StDecode : StFetch;
            end
            StDecode: begin
                alu_src_b_o2 = 2'b11;
                case (op_i6)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    state_d = StRtypeEx;
                    OpBeq:      state_d = StBeqEx;
                    OpAddi:     state_d = StAddiEx;
                    OpJ:        state_d = StJEx;
`ifdef MC_BNE_EN
                    OpBne:      state_d = StBneEx;
`endif
                    default: begin
                        state_d     = StFetch;
                        illegal_raw = 1'b1;
                    end
                endcase
            end
            StMemAdr: begin
                alu_src_a_o  = 1'b1;
                alu_src_b_o2 = 2'b10;
                // Only lw/sw reach this state, so anything not lw is sw.
                state_d      = (op_i6 == OpLw) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                iord_o  = 1'b1;
                state_d = mem_ready_i ? StMemWb : StMemRd;
            end
            StMemWb: begin
                mem_to_reg_o  = 1'b1;
                reg_write_raw = 1'b1;
            end
            StMemWr: begin
                iord_o        = 1'b1;
                mem_write_raw = 1'b1;
                state_d       = mem_ready_i ? StFetch : StMemWr;
            end
            StRtypeEx: begin
                alu_src_a_o = 1'b1;
                alu_op_o2   = 2'b10;
                state_d     = StRtypeWb;
            end
            StRtypeWb: begin
                reg_dst_o     = 1'b1;
                reg_write_raw = 1'b1;
            end
            StBeqEx: begin
                alu_src_a_o = 1'b1;
                alu_op_o2   = 2'b01;
                pc_src_o2   = 2'b01;
                branch_eq   = 1'b1;
            end
            StAddiEx: begin
                alu_src_a_o  = 1'b1;
                alu_src_b_o2 = 2'b10;
                state_d      = StAddiWb;
            end
            StAddiWb: begin
                reg_write_raw = 1'b1;
            end
            StJEx: begin
                pc_src_o2 = 2'b10;
                pc_write  = 1'b1;
            end
`ifdef MC_BNE_EN
            StBneEx: begin
                alu_src_a_o = 1'b1;
                alu_op_o2   = 2'b01;
                pc_src_o2   = 2'b01;
                branch_ne   = 1'b1;
            end
`endif
            // Undefined encodings drive nothing and fall back to FETCH.
            default: state_d = StFetch;
        endcase
    end

    // Gating by rst_i keeps a reset mid-instruction from leaking a partial write.
    assign ir_write_o   = ir_write_raw & ~rst_i;
    assign mem_write_o  = mem_write_raw & ~rst_i;
    assign reg_write_o  = reg_write_raw & ~rst_i;
    assign illegal_op_o = illegal_raw & ~rst_i;
    assign pc_en_o      = (pc_write | (branch_eq & zero_i) | (branch_ne & ~zero_i)) & ~rst_i;
    assign state_o4     = state_q;

endmodule

// File: doc/mc_main_ctrl.md
Name: mc_main_ctrl

Overview:
Main control FSM for the multicycle MIPS core. It sequences each instruction through fetch, decode, execute, memory and writeback steps, and drives every datapath mux select and write enable. It produces alu_op_o2, which feeds the existing ALU decoder's alu_op input alongside the instruction funct field. It also handles a memory-ready handshake and flags illegal opcodes.

Parameters:
RESET_STATE, 4'd0, state entered on reset (FETCH); must not be changed from FETCH in production builds.

Ports:
clk_i  in  1  system clock, rising edge
rst_i  in  1  asynchronous, active-high reset
op_i6  in  6  opcode field (instr[31:26]) from the instruction register
zero_i  in  1  ALU zero flag
mem_ready_i  in  1  unified memory has completed the current read/write this cycle
iord_o  out  1  memory address select: 0=PC, 1=ALUOut
alu_src_a_o  out  1  ALU A select: 0=PC, 1=regA
alu_src_b_o2  out  2  ALU B select: 00=regB, 01=4, 10=SignImm, 11=SignImm<<2
alu_op_o2  out  2  00=add, 01=sub, 10=use funct
pc_src_o2  out  2  00=ALUResult, 01=ALUOut, 10=jump target
ir_write_o  out  1  instruction register load
mem_write_o  out  1  memory write strobe
reg_write_o  out  1  register file write
reg_dst_o  out  1  destination: 0=rt, 1=rd
mem_to_reg_o  out  1  writeback: 0=ALUOut, 1=Data
pc_en_o  out  1  PC load = pc_write | (branch & zero_i)
illegal_op_o  out  1  one-cycle pulse in DECODE on an unsupported opcode
state_o4  out  4  current state, for debug/trace

Behaviour:
- Asynchronous, active-high reset: state goes to FETCH immediately. While rst_i=1, ir_write_o, mem_write_o, reg_write_o, pc_en_o and illegal_op_o are forced to 0. All other outputs take their FETCH values.
- State register: 4 bits. Encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11, BNEEX=12 (optional). Any other encoding goes to FETCH on the next edge.
- Outputs are decoded from state (Moore), except for the mem_ready_i gating and zero_i noted below. Any signal not listed for a state is 0.
- FETCH: iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. ir_write and pc_write equal mem_ready_i. Stay in FETCH until mem_ready_i=1, then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
  - lw 100011 or sw 101011 → MEMADR
  - R-type 000000 → RTYPEEX
  - beq 000100 → BEQEX
  - addi 001000 → ADDIEX
  - j 000010 → JEX
  - any other opcode → FETCH, with illegal_op_o=1 for this cycle
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state: lw → MEMRD, sw → MEMWR.
- MEMRD: iord=1. Hold until mem_ready_i=1, then → MEMWB.
- MEMWR: iord=1, mem_write=1. mem_write stays asserted while waiting for mem_ready_i. On mem_ready_i=1 → FETCH.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1 → FETCH.
- RTYPEEX: alu_src_a=1, alu_src_b=00, alu_op=10 → RTYPEWB.
- RTYPEWB: reg_dst=1, mem_to_reg=0, reg_write=1 → FETCH.
- BEQEX: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1 → FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00 → ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1 → FETCH.
- JEX: pc_src=10, pc_write=1 → FETCH.
- Cycles per instruction with memory always ready: lw=5, sw=4, R-type=4, addi=4, beq=3, j=3. Each cycle of mem_ready_i=0 in FETCH, MEMRD or MEMWR adds one cycle.
- op_i6 is sampled only in DECODE and MEMADR. The IR is stable in those states because ir_write is 0 outside FETCH.
- Reset asserted mid-instruction: the FSM returns to FETCH and no partial write occurs, because the write enables are gated by rst_i.

Optional Feature:
MC_BNE_EN:
- Defined: opcode 000101 (bne) in DECODE goes to BNEEX. BNEEX has the same outputs as BEQEX, but pc_en_o = ~zero_i.
- Undefined: 000101 is treated as illegal (illegal_op_o pulse, return to FETCH), and encoding 12 behaves as an undefined encoding.

Test Plan:
- Reset asserted mid-MEMWR with mem_ready_i=1 → mem_write_o=0 immediately; after release, state_o4=0 and ir_write_o follows mem_ready_i.
- lw (op 100011), mem_ready_i tied to 1 → state sequence 0,1,2,3,4,0; reg_write_o=1 and mem_to_reg_o=1 only in state 4.
- sw with mem_ready_i=0 for 3 cycles in MEMWR → mem_write_o held at 1 for 4 cycles, then state returns to 0.
- beq with zero_i=1 → pc_en_o=1 in BEQEX; with zero_i=0 → pc_en_o=0; alu_op_o2=01 in both cases.
- R-type → alu_op_o2=10 in state 6; reg_dst_o=1 and reg_write_o=1 in state 7. j → pc_src_o2=10 and pc_en_o=1 in state 11.
- op 111111 → illegal_op_o pulses for 1 cycle in DECODE, then state=0. bne (000101) with MC_BNE_EN defined and zero_i=0 → pc_en_o=1; without MC_BNE_EN → illegal_op_o=1.
